// File: rtl/acc_result_drain_arbiter_pkg.sv
// Shared channel indices, FSM encoding and round-robin helper for the result drain arbiter.
package acc_arb_pkg;

  localparam int NUM_CH = 3;

  localparam logic [1:0] CH_FFT = 2'd0;
  localparam logic [1:0] CH_FIR = 2'd1;
  localparam logic [1:0] CH_IIR = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    CAP  = 2'd2,
    WR   = 2'd3
  } state_t;

  // Next channel in rotation order, wrapping IIR back to FFT.
  function automatic logic [1:0] next_chan(input logic [1:0] c);
    return (c == CH_IIR) ? CH_FFT : (c + 2'd1);
  endfunction

endpackage

// File: rtl/acc_result_drain_arbiter_rr_arbiter3.sv
// Three-way round-robin pick: first eligible channel at or above the pointer, wrapping.
// Purely combinational; zero latency, no backpressure.
module rr_arbiter3
  import acc_arb_pkg::*;
(
  input  logic [2:0] i_eligible,
  input  logic [1:0] i_ptr,
  output logic       o_grant_valid,
  output logic [1:0] o_grant_idx
);

  logic [1:0] w_c0;
  logic [1:0] w_c1;
  logic [1:0] w_c2;

  assign w_c0 = (i_ptr == 2'd3) ? CH_FFT : i_ptr;
  assign w_c1 = next_chan(w_c0);
  assign w_c2 = next_chan(w_c1);

  always_comb begin
    o_grant_valid = 1'b0;
    o_grant_idx   = CH_FFT;
    if (i_eligible[w_c0]) begin
      o_grant_valid = 1'b1;
      o_grant_idx   = w_c0;
    end else if (i_eligible[w_c1]) begin
      o_grant_valid = 1'b1;
      o_grant_idx   = w_c1;
    end else if (i_eligible[w_c2]) begin
      o_grant_valid = 1'b1;
      o_grant_idx   = w_c2;
    end
  end

endmodule

// File: rtl/acc_result_drain_arbiter.sv
// Drains FFT/FIR/IIR return FIFOs into RAM round-robin in bursts of up to BURST words.
// Three cycles per word (REQ, CAP, WR) plus one IDLE cycle between grants; an empty FIFO ends a burst early.
module acc_result_drain_arbiter
  import acc_arb_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int CNT_W    = 16,
  parameter int BURST    = 4,
  parameter int ADDR_INC = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_load,
  input  logic [1:0]        cfg_chan,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [CNT_W-1:0]  cfg_count,
  output logic              cfg_err,
  input  logic              from_fft_empty,
  input  logic              from_fir_empty,
  input  logic              from_iir_empty,
  input  logic [DATA_W-1:0] fft_data_in,
  input  logic [DATA_W-1:0] fir_data_in,
  input  logic [DATA_W-1:0] iir_data_in,
  output logic              fft_get_req,
  output logic              fir_get_req,
  output logic              iir_get_req,
  output logic              ram_write_enable,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] ram_data_out,
  output logic [2:0]        chan_done,
  output logic              busy
);

  localparam int BEAT_W = $clog2(BURST + 1);
  localparam logic [BEAT_W-1:0] BURST_L = BEAT_W'(BURST);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [1:0]          r_grant;
  logic [1:0]          r_rr;
  logic [BEAT_W-1:0]   r_beat;
  logic [ADDR_W-1:0]   r_addr_ptr [NUM_CH];
  logic [CNT_W-1:0]    r_remaining [NUM_CH];
  logic [2:0]          r_done;
  logic                r_cfg_err;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_data;

  logic [2:0]          w_empty;
  logic [2:0]          w_eligible;
  logic                w_gnt_vld;
  logic [1:0]          w_gnt_idx;
  logic [DATA_W-1:0]   w_fifo_data;
  logic                w_cfg_ok;
  logic [CNT_W-1:0]    w_rem_dec;
  logic [BEAT_W-1:0]   w_beat_nxt;
  logic                w_continue;

  assign w_empty = {from_iir_empty, from_fir_empty, from_fft_empty};

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_eligible[i] = (r_remaining[i] != '0) && !w_empty[i];
    end
  end

  rr_arbiter3 u_rr (
    .i_eligible   (w_eligible),
    .i_ptr        (r_rr),
    .o_grant_valid(w_gnt_vld),
    .o_grant_idx  (w_gnt_idx)
  );

  assign w_fifo_data = (r_grant == CH_FIR) ? fir_data_in :
                       (r_grant == CH_IIR) ? iir_data_in : fft_data_in;

  // Rewriting the channel being drained would corrupt its pointer mid-burst.
  assign w_cfg_ok   = (cfg_chan != 2'd3) && !(busy && (cfg_chan == r_grant));
  assign w_rem_dec  = r_remaining[r_grant] - CNT_W'(1);
  assign w_beat_nxt = r_beat + BEAT_W'(1);
  assign w_continue = (w_rem_dec != '0) && (w_beat_nxt < BURST_L) && !w_empty[r_grant];

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt      = r_state;
    busy             = 1'b0;
    ram_write_enable = 1'b0;
    fft_get_req      = 1'b0;
    fir_get_req      = 1'b0;
    iir_get_req      = 1'b0;
    case (r_state)
      IDLE: if (w_gnt_vld) w_state_nxt = REQ;
      REQ: begin
        busy        = 1'b1;
        fft_get_req = (r_grant == CH_FFT);
        fir_get_req = (r_grant == CH_FIR);
        iir_get_req = (r_grant == CH_IIR);
        w_state_nxt = CAP;
      end
      CAP: begin
        busy        = 1'b1;
        w_state_nxt = WR;
      end
      WR: begin
        busy             = 1'b1;
        ram_write_enable = 1'b1;
        w_state_nxt      = w_continue ? REQ : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant   <= CH_FFT;
      r_rr      <= CH_FFT;
      r_beat    <= '0;
      r_done    <= '0;
      r_cfg_err <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_addr_ptr[i]  <= '0;
        r_remaining[i] <= '0;
      end
    end else begin
      r_cfg_err <= cfg_load && !w_cfg_ok;
      if (r_state == IDLE && w_gnt_vld) begin
        r_grant <= w_gnt_idx;
        r_beat  <= '0;
      end
      if (r_state == CAP) begin
        r_data <= w_fifo_data;
        r_addr <= r_addr_ptr[r_grant];
      end
      if (r_state == WR) begin
        r_beat <= w_beat_nxt;
        if (!w_continue) r_rr <= next_chan(r_grant);
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (r_state == WR && r_grant == 2'(i)) begin
          r_addr_ptr[i]  <= r_addr_ptr[i] + ADDR_W'(ADDR_INC);
          r_remaining[i] <= w_rem_dec;
          if (w_rem_dec == '0) r_done[i] <= 1'b1;
        end else if (cfg_load && w_cfg_ok && cfg_chan == 2'(i)) begin
          r_addr_ptr[i]  <= cfg_addr;
          r_remaining[i] <= cfg_count;
          r_done[i]      <= (cfg_count == '0);
        end
      end
    end
  end

  assign cfg_err      = r_cfg_err;
  assign addr         = r_addr;
  assign ram_data_out = r_data;
  assign chan_done    = r_done;

endmodule

// File: tb/tb_acc_result_drain_arbiter.sv
// Directed bench: behavioural FIFOs feed the arbiter, a monitor logs RAM writes and get_req pulses.
module tb_acc_result_drain_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_load;
  logic [1:0]  cfg_chan;
  logic [31:0] cfg_addr;
  logic [15:0] cfg_count;
  logic        cfg_err;
  logic        from_fft_empty, from_fir_empty, from_iir_empty;
  logic [31:0] fft_data_in, fir_data_in, iir_data_in;
  logic        fft_get_req, fir_get_req, iir_get_req;
  logic        ram_write_enable;
  logic [31:0] addr;
  logic [31:0] ram_data_out;
  logic [2:0]  chan_done;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  acc_result_drain_arbiter dut (
    .clk(clk), .reset(reset),
    .cfg_load(cfg_load), .cfg_chan(cfg_chan), .cfg_addr(cfg_addr), .cfg_count(cfg_count),
    .cfg_err(cfg_err),
    .from_fft_empty(from_fft_empty), .from_fir_empty(from_fir_empty), .from_iir_empty(from_iir_empty),
    .fft_data_in(fft_data_in), .fir_data_in(fir_data_in), .iir_data_in(iir_data_in),
    .fft_get_req(fft_get_req), .fir_get_req(fir_get_req), .iir_get_req(iir_get_req),
    .ram_write_enable(ram_write_enable), .addr(addr), .ram_data_out(ram_data_out),
    .chan_done(chan_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // FIFO models: data appears on *_data_in the cycle after get_req.
  logic [31:0] fmem [3][64];
  int frd [3] = '{0, 0, 0};
  int fwr [3] = '{0, 0, 0};

  assign from_fft_empty = (frd[0] == fwr[0]);
  assign from_fir_empty = (frd[1] == fwr[1]);
  assign from_iir_empty = (frd[2] == fwr[2]);

  always @(posedge clk) begin
    if (fft_get_req) begin fft_data_in <= fmem[0][frd[0] % 64]; frd[0] <= frd[0] + 1; end
    if (fir_get_req) begin fir_data_in <= fmem[1][frd[1] % 64]; frd[1] <= frd[1] + 1; end
    if (iir_get_req) begin iir_data_in <= fmem[2][frd[2] % 64]; frd[2] <= frd[2] + 1; end
  end

  logic [31:0] wr_addr [256];
  logic [31:0] wr_data [256];
  int          wr_cyc  [256];
  int          n_wr = 0;
  int          gcnt [3] = '{0, 0, 0};
  int          cyc = 0;
  bit          overlap = 1'b0;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (ram_write_enable) begin
      if (n_wr < 256) begin
        wr_addr[n_wr] = addr;
        wr_data[n_wr] = ram_data_out;
        wr_cyc[n_wr]  = cyc;
      end
      n_wr++;
    end
    if (fft_get_req) gcnt[0]++;
    if (fir_get_req) gcnt[1]++;
    if (iir_get_req) gcnt[2]++;
    if ((int'(fft_get_req) + int'(fir_get_req) + int'(iir_get_req)) > 1) overlap = 1'b1;
  end

  task automatic clear_log();
    n_wr = 0;
    for (int i = 0; i < 3; i++) gcnt[i] = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    cfg_load = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) fwr[i] = frd[i];
    reset = 1'b0;
    clear_log();
  endtask

  task automatic push(input int ch, input logic [31:0] d);
    fmem[ch][fwr[ch] % 64] = d;
    fwr[ch] = fwr[ch] + 1;
  endtask

  // Called at a negedge; returns at the negedge after the load edge.
  task automatic cfg(input logic [1:0] ch, input logic [31:0] a, input logic [15:0] c);
    cfg_load  = 1'b1;
    cfg_chan  = ch;
    cfg_addr  = a;
    cfg_count = c;
    @(posedge clk);
    @(negedge clk);
    cfg_load = 1'b0;
  endtask

  task automatic wait_writes(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (n_wr >= n) break;
      @(negedge clk);
    end
    ok = (n_wr >= n);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (chan_done !== 3'b000) begin n_fail++; $display("FAIL reset_done got %b want 000", chan_done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if ({fft_get_req, fir_get_req, iir_get_req, ram_write_enable, cfg_err} !== 5'b0) begin
      n_fail++; $display("FAIL reset_strobes got %b want 00000", {fft_get_req, fir_get_req, iir_get_req, ram_write_enable, cfg_err}); end
    n_checks++; if ({addr, ram_data_out} !== 64'h0) begin n_fail++; $display("FAIL reset_addr_data got %h/%h want 0/0", addr, ram_data_out); end
  endtask

  task automatic test_single();
    bit ok;
    do_reset();
    push(1, 32'hA); push(1, 32'hB); push(1, 32'hC);
    cfg(2'd1, 32'h100, 16'd3);
    wait_writes(3, 60, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL single_timeout got %0d writes want 3", n_wr); end
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (wr_addr[k] !== 32'h100 + 32'(k) || wr_data[k] !== 32'hA + 32'(k)) begin
        n_fail++; $display("FAIL single_write%0d got %h@%h want %h@%h", k, wr_data[k], wr_addr[k], 32'hA + 32'(k), 32'h100 + 32'(k));
      end
    end
    n_checks++; if (wr_cyc[1] - wr_cyc[0] !== 3 || wr_cyc[2] - wr_cyc[1] !== 3) begin
      n_fail++; $display("FAIL single_spacing got %0d,%0d want 3,3", wr_cyc[1] - wr_cyc[0], wr_cyc[2] - wr_cyc[1]); end
    repeat (5) @(negedge clk);
    n_checks++; if (chan_done !== 3'b010) begin n_fail++; $display("FAIL single_done got %b want 010", chan_done); end
    n_checks++; if (gcnt[1] !== 3) begin n_fail++; $display("FAIL single_getreq got %0d want 3", gcnt[1]); end
  endtask

  task automatic test_fairness();
    bit ok;
    int ch, idx;
    do_reset();
    for (int c = 0; c < 3; c++)
      for (int i = 0; i < 8; i++) push(c, 32'(c * 256 + i));
    cfg(2'd0, 32'h1000, 16'd8);
    cfg(2'd1, 32'h2000, 16'd8);
    cfg(2'd2, 32'h3000, 16'd8);
    wait_writes(24, 400, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL fair_timeout got %0d writes want 24", n_wr); end
    for (int k = 0; k < 24; k++) begin
      ch  = (k / 4) % 3;
      idx = (k / 12) * 4 + (k % 4);
      n_checks++;
      if (wr_data[k] !== 32'(ch * 256 + idx) || wr_addr[k] !== 32'(32'h1000 * (ch + 1) + idx)) begin
        n_fail++; $display("FAIL fair_write%0d got %h@%h want %h@%h", k, wr_data[k], wr_addr[k],
                           32'(ch * 256 + idx), 32'(32'h1000 * (ch + 1) + idx));
      end
    end
    repeat (5) @(negedge clk);
    n_checks++; if (chan_done !== 3'b111) begin n_fail++; $display("FAIL fair_done got %b want 111", chan_done); end
  endtask

  task automatic test_starve();
    bit ok;
    do_reset();
    push(0, 32'h50); push(0, 32'h51);
    cfg(2'd0, 32'h200, 16'd5);
    wait_writes(2, 60, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL starve_timeout got %0d writes want 2", n_wr); end
    repeat (10) @(negedge clk);
    n_checks++; if (n_wr !== 2) begin n_fail++; $display("FAIL starve_count got %0d want 2", n_wr); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL starve_busy got %b want 0", busy); end
    n_checks++; if (chan_done !== 3'b000) begin n_fail++; $display("FAIL starve_done_early got %b want 000", chan_done); end
    push(0, 32'h52); push(0, 32'h53); push(0, 32'h54);
    wait_writes(5, 100, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL starve_resume_timeout got %0d writes want 5", n_wr); end
    n_checks++; if (wr_addr[2] !== 32'h202 || wr_data[2] !== 32'h52) begin
      n_fail++; $display("FAIL starve_resume got %h@%h want 52@202", wr_data[2], wr_addr[2]); end
    n_checks++; if (wr_addr[4] !== 32'h204 || wr_data[4] !== 32'h54) begin
      n_fail++; $display("FAIL starve_last got %h@%h want 54@204", wr_data[4], wr_addr[4]); end
    repeat (5) @(negedge clk);
    n_checks++; if (chan_done !== 3'b001) begin n_fail++; $display("FAIL starve_done got %b want 001", chan_done); end
  endtask

  task automatic test_cfg_illegal();
    do_reset();
    cfg(2'd3, 32'h77, 16'd5);
    n_checks++; if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL illegal_err got %b want 1", cfg_err); end
    @(negedge clk);
    n_checks++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL illegal_err_pulse got %b want 0", cfg_err); end
    push(0, 32'h1); push(1, 32'h2); push(2, 32'h3);
    repeat (10) @(negedge clk);
    n_checks++; if (n_wr !== 0 || busy !== 1'b0 || chan_done !== 3'b000) begin
      n_fail++; $display("FAIL illegal_nochange got writes=%0d busy=%b done=%b want 0/0/000", n_wr, busy, chan_done); end
  endtask

  task automatic test_cfg_granted();
    bit ok;
    do_reset();
    for (int i = 0; i < 4; i++) push(1, 32'h31 + 32'(i));
    cfg(2'd1, 32'h300, 16'd4);
    wait_writes(1, 60, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL granted_timeout got %0d writes want 1", n_wr); end
    cfg(2'd1, 32'h999, 16'd1);
    n_checks++; if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL granted_err got %b want 1", cfg_err); end
    wait_writes(4, 100, ok);
    repeat (10) @(negedge clk);
    n_checks++; if (n_wr !== 4) begin n_fail++; $display("FAIL granted_count got %0d want 4", n_wr); end
    n_checks++; if (wr_addr[3] !== 32'h303 || wr_data[3] !== 32'h34) begin
      n_fail++; $display("FAIL granted_last got %h@%h want 34@303", wr_data[3], wr_addr[3]); end
    n_checks++; if (chan_done !== 3'b010) begin n_fail++; $display("FAIL granted_done got %b want 010", chan_done); end
  endtask

  task automatic test_cfg_zero();
    do_reset();
    push(2, 32'h41); push(2, 32'h42);
    cfg(2'd2, 32'h400, 16'd0);
    n_checks++; if (chan_done !== 3'b100) begin n_fail++; $display("FAIL zero_done got %b want 100", chan_done); end
    n_checks++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL zero_err got %b want 0", cfg_err); end
    repeat (10) @(negedge clk);
    n_checks++; if (n_wr !== 0 || gcnt[2] !== 0) begin
      n_fail++; $display("FAIL zero_nowrite got writes=%0d gets=%0d want 0/0", n_wr, gcnt[2]); end
  endtask

  task automatic test_wrap();
    bit ok;
    do_reset();
    push(0, 32'hAA); push(0, 32'hBB);
    cfg(2'd0, 32'hFFFF_FFFF, 16'd2);
    wait_writes(2, 60, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL wrap_timeout got %0d writes want 2", n_wr); end
    n_checks++; if (wr_addr[0] !== 32'hFFFF_FFFF || wr_addr[1] !== 32'h0) begin
      n_fail++; $display("FAIL wrap_addr got %h,%h want ffffffff,00000000", wr_addr[0], wr_addr[1]); end
    repeat (5) @(negedge clk);
    n_checks++; if (chan_done !== 3'b001) begin n_fail++; $display("FAIL wrap_done got %b want 001", chan_done); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    for (int i = 0; i < 4; i++) push(1, 32'hD1 + 32'(i));
    cfg(2'd1, 32'h500, 16'd4);
    wait_writes(2, 60, ok);
    n_checks++; if (!ok || ram_write_enable !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_inwr got writes=%0d we=%b want 2/1", n_wr, ram_write_enable); end
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if ({busy, fft_get_req, fir_get_req, iir_get_req, ram_write_enable, cfg_err, chan_done} !== 9'b0 ||
                    {addr, ram_data_out} !== 64'h0) begin
      n_fail++; $display("FAIL rstmid_outputs got busy=%b we=%b done=%b addr=%h data=%h want all 0",
                         busy, ram_write_enable, chan_done, addr, ram_data_out); end
    reset = 1'b0;
    repeat (10) @(negedge clk);
    n_checks++; if (gcnt[1] !== 2 || n_wr !== 2) begin
      n_fail++; $display("FAIL rstmid_quiet got gets=%0d writes=%0d want 2/2", gcnt[1], n_wr); end
    clear_log();
    cfg(2'd1, 32'h600, 16'd2);
    wait_writes(2, 60, ok);
    n_checks++; if (!ok || wr_addr[0] !== 32'h600 || wr_data[0] !== 32'hD3 || wr_addr[1] !== 32'h601 || wr_data[1] !== 32'hD4) begin
      n_fail++; $display("FAIL rstmid_reload got %h@%h %h@%h want d3@600 d4@601", wr_data[0], wr_addr[0], wr_data[1], wr_addr[1]); end
    repeat (5) @(negedge clk);
    n_checks++; if (chan_done !== 3'b010) begin n_fail++; $display("FAIL rstmid_done got %b want 010", chan_done); end
  endtask

  initial begin
    reset     = 1'b1;
    cfg_load  = 1'b0;
    cfg_chan  = 2'd0;
    cfg_addr  = 32'h0;
    cfg_count = 16'h0;
    fft_data_in = 32'h0;
    fir_data_in = 32'h0;
    iir_data_in = 32'h0;
    test_reset();
    test_single();
    test_fairness();
    test_starve();
    test_cfg_illegal();
    test_cfg_granted();
    test_cfg_zero();
    test_wrap();
    test_reset_mid();
    n_checks++; if (overlap !== 1'b0) begin n_fail++; $display("FAIL getreq_overlap got %b want 0", overlap); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
